// File: rtl/l1l2_bus_pkg.sv
// l1l2_bus_pkg: shared L1<->L2 bus constants, write-enable polarity, arbiter states and port indices.
package l1l2_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ = 1'b1;
  localparam int PORT_D = 0;
  localparam int PORT_I = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
endpackage

// File: rtl/l2_rr_pick.sv
// l2_rr_pick: combinational 2-way round-robin pick; on a tie the port that did not win last goes.
module l2_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the L1->L2 bus between D-cache (port 0) and I-cache (port 1),
// one transaction at a time, with a strobe timeout that completes the transaction with err.
module l2_port_arbiter #(
  parameter int ADDR_W  = l1l2_bus_pkg::ADDR_W,
  parameter int DATA_W  = l1l2_bus_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we_n,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              l2_req,
  output logic              l2_we_n,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_stb_n
);
  import l1l2_bus_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] gnt_q, gnt_d, pick;
  logic we_q, we_d, last_q, last_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  l2_rr_pick u_pick (.req(req), .last(last_q), .gnt(pick));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (|req) begin
        state_d = ST_BUSY;
        gnt_d   = pick;
        addr_d  = pick[PORT_I] ? req_addr1 : req_addr0;
        wdata_d = pick[PORT_I] ? req_wdata1 : req_wdata0;
        we_d    = pick[PORT_I] ? req_we_n[PORT_I] : req_we_n[PORT_D];
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      ST_BUSY: if (!l2_stb_n) begin
        state_d = ST_RESP;
        rdata_d = l2_rdata;
        err_d   = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = ST_RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = gnt_q[PORT_I];
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      we_q    <= WE_READ;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign l2_req   = state_q == ST_BUSY;
  assign l2_we_n  = l2_req ? we_q : WE_READ;
  assign l2_addr  = addr_q;
  assign l2_wdata = wdata_q;
  assign done     = (state_q == ST_RESP) ? gnt_q : 2'b00;
  assign err      = (state_q == ST_RESP) & err_q;
  assign rdata    = rdata_q;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed table of transactions plus hand-written reset/strobe corner sequences.
module tb_l2_port_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = 2'b11, req_we_n = 2'b11;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [63:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0] done;
  logic err, l2_req, l2_we_n;
  logic [63:0] rdata, l2_wdata;
  logic [31:0] l2_addr;
  logic [63:0] l2_rdata = '0;
  logic l2_stb_n = 1'b1;
  int errors = 0, checks = 0;
  l2_port_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we_n(req_we_n),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .done(done), .err(err), .rdata(rdata),
    .l2_req(l2_req), .l2_we_n(l2_we_n), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_stb_n(l2_stb_n)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we_n;
    logic [31:0] a0, a1;
    logic [63:0] w0, w1;
    int          stb_at;
    logic [63:0] l2rd;
    logic        keep, drop;
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic        we;
    logic [63:0] wdata, rd;
    logic        err;
    int          busy;
  } vec_t;
  vec_t v [10];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input vec_t t);
    int busy;
    req_we_n = t.we_n;
    req_addr0 = t.a0;
    req_addr1 = t.a1;
    req_wdata0 = t.w0;
    req_wdata1 = t.w1;
    req = t.req;
    for (int i = 0; i < 20 && !l2_req; i++) tick();
    chk("l2_req_start", 64'(l2_req), 64'd1);
    if (!l2_req) return;
    busy = 1;
    for (int i = 0; i < 40; i++) begin
      chk("l2_addr", 64'(l2_addr), 64'(t.addr));
      chk("l2_we_n", 64'(l2_we_n), 64'(t.we));
      chk("l2_wdata", l2_wdata, t.wdata);
      if (busy == 1) begin
        if (t.gnt[1]) begin req_addr1 = ~req_addr1; req_wdata1 = ~req_wdata1; req_we_n[1] = ~req_we_n[1]; end
        else begin req_addr0 = ~req_addr0; req_wdata0 = ~req_wdata0; req_we_n[0] = ~req_we_n[0]; end
        if (t.drop) req = 2'b00;
      end
      if (busy - 1 == t.stb_at) begin
        l2_stb_n = 1'b0;
        l2_rdata = t.l2rd;
      end
      tick();
      l2_stb_n = 1'b1;
      l2_rdata = 64'hFFFF_0000_FFFF_0000;
      if (!l2_req) break;
      busy++;
    end
    chk("busy_cycles", 64'(busy), 64'(t.busy));
    chk("done", 64'(done), 64'(t.gnt));
    chk("err", 64'(err), 64'(t.err));
    chk("rdata", rdata, t.rd);
    chk("resp_we_n", 64'(l2_we_n), 64'd1);
    if (!t.keep) req = 2'b00;
    tick();
    chk("done_clear", 64'(done), 64'd0);
    chk("err_clear", 64'(err), 64'd0);
    chk("idle_gap", 64'(l2_req), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    v[0] = '{2'b11, 2'b11, 32'h100, 32'h200, 64'h10, 64'h20, 0, 64'h11, 0, 0,
             2'b01, 32'h100, 1'b1, 64'h10, 64'h11, 1'b0, 1};
    v[1] = '{2'b01, 2'b11, 32'h0000_1040, 32'h0, 64'h0, 64'h0, 2, 64'h0000_1040_0000_0000, 0, 0,
             2'b01, 32'h0000_1040, 1'b1, 64'h0, 64'h0000_1040_0000_0000, 1'b0, 3};
    v[2] = '{2'b10, 2'b01, 32'h0, 32'hDEAD_BEE0, 64'h0, 64'hDEAD_BEE0_0000_0000, 0, 64'h1234, 0, 0,
             2'b10, 32'hDEAD_BEE0, 1'b0, 64'hDEAD_BEE0_0000_0000, 64'h1234, 1'b0, 1};
    v[3] = '{2'b11, 2'b11, 32'hA000, 32'hB000, 64'hAA, 64'hBB, 1, 64'hC0, 1, 0,
             2'b01, 32'hA000, 1'b1, 64'hAA, 64'hC0, 1'b0, 2};
    v[4] = '{2'b11, 2'b11, 32'hA000, 32'hB000, 64'hAA, 64'hBB, 1, 64'hC1, 1, 0,
             2'b10, 32'hB000, 1'b1, 64'hBB, 64'hC1, 1'b0, 2};
    v[5] = '{2'b11, 2'b11, 32'hA000, 32'hB000, 64'hAA, 64'hBB, 1, 64'hC2, 1, 0,
             2'b01, 32'hA000, 1'b1, 64'hAA, 64'hC2, 1'b0, 2};
    v[6] = '{2'b11, 2'b11, 32'hA000, 32'hB000, 64'hAA, 64'hBB, 1, 64'hC3, 0, 0,
             2'b10, 32'hB000, 1'b1, 64'hBB, 64'hC3, 1'b0, 2};
    v[7] = '{2'b01, 2'b11, 32'h3000, 32'h0, 64'h0, 64'h0, -1, 64'hDEAD, 0, 0,
             2'b01, 32'h3000, 1'b1, 64'h0, 64'h0, 1'b1, TO};
    v[8] = '{2'b01, 2'b11, 32'h3008, 32'h0, 64'h0, 64'h0, TO - 1, 64'hA5A5, 0, 1,
             2'b01, 32'h3008, 1'b1, 64'h0, 64'hA5A5, 1'b0, TO};
    v[9] = '{2'b01, 2'b10, 32'h4000, 32'h0, 64'h5555_6666_7777_8888, 64'h0, 0, 64'h77, 0, 0,
             2'b01, 32'h4000, 1'b0, 64'h5555_6666_7777_8888, 64'h77, 1'b0, 1};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_l2_req", 64'(l2_req), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_we_n", 64'(l2_we_n), 64'd1);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run(v[i]);
    req = 2'b00;
    l2_stb_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_stb_done", 64'(done), 64'd0);
      chk("idle_stb_l2_req", 64'(l2_req), 64'd0);
    end
    l2_stb_n = 1'b1;
    req_addr0 = 32'h6000;
    req_we_n = 2'b11;
    req = 2'b01;
    for (int i = 0; i < 20 && !l2_req; i++) tick();
    chk("held_l2_req", 64'(l2_req), 64'd1);
    l2_stb_n = 1'b0;
    l2_rdata = 64'h99;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done != 2'b00) begin
        n++;
        chk("held_rdata", rdata, 64'h99);
        req = 2'b00;
      end
    end
    chk("held_done_count", 64'(n), 64'd1);
    l2_stb_n = 1'b1;
    tick();
    req_addr0 = 32'h7000;
    req = 2'b01;
    for (int i = 0; i < 20 && !l2_req; i++) tick();
    chk("rstmid_l2_req", 64'(l2_req), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_l2_req_low", 64'(l2_req), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    rst = 1'b0;
    req = 2'b00;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done != 2'b00 || l2_req) n++;
    end
    chk("rstmid_quiet", 64'(n), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
